// File: rtl/fb_rect_fill_if.sv
// Command and pixel-write bundle for the rectangle fill engine.
// The engine takes the slave side; the command source/framebuffer side takes master.
interface fb_rect_fill_if #(
    parameter int FB_X = 1280,
    parameter int FB_Y = 720
);
    localparam int X_BITS       = $clog2(FB_X);
    localparam int Y_BITS       = $clog2(FB_Y);
    localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y);

    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [X_BITS:0]         cmd_x_i;
    logic [Y_BITS:0]         cmd_y_i;
    logic [X_BITS:0]         cmd_w_i;
    logic [Y_BITS:0]         cmd_h_i;
    logic [23:0]             cmd_color_i;
    logic [FB_ADDR_BITS-1:0] pxl_addr_o;
    logic [23:0]             pxl_data_o;
    logic                    pxl_en_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i,
        output cmd_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i,
        input  cmd_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, busy_o, done_o
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips a command to the framebuffer and streams one
// linear-address pixel write per cycle, row-major, with no multiply in the loop.
module fb_rect_fill #(
    parameter int FB_X = 1280,
    parameter int FB_Y = 720
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    fb_rect_fill_if.slave bus
);
    localparam int X_BITS       = $clog2(FB_X);
    localparam int Y_BITS       = $clog2(FB_Y);
    localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y);
    localparam int XW           = X_BITS + 1;
    localparam int YW           = Y_BITS + 1;
    localparam int AW           = FB_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;
    state_t state, state_nxt;

    logic [XW-1:0] x_r, w_r, w_eff, col, w_rem, w_clip;
    logic [YW-1:0] y_r, h_r, h_eff, row, h_rem, h_clip;
    logic [AW-1:0] start_addr, row_step;
    logic          drop, col_end, last;

    assign bus.cmd_ready_o = (state == IDLE);

    always_comb begin
        // Remaining span is only meaningful when the origin is on-screen.
        w_rem      = XW'(FB_X) - x_r;
        h_rem      = YW'(FB_Y) - y_r;
        w_clip     = (w_r < w_rem) ? w_r : w_rem;
        h_clip     = (h_r < h_rem) ? h_r : h_rem;
        drop       = (x_r >= XW'(FB_X)) || (y_r >= YW'(FB_Y)) ||
                     (w_r == '0) || (h_r == '0);
        start_addr = AW'(y_r) * AW'(FB_X) + AW'(x_r);
        row_step   = AW'(FB_X) - AW'(w_eff) + AW'(1);
        col_end    = (col == w_eff - XW'(1));
        last       = col_end && (row == h_eff - YW'(1));

        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid_i) state_nxt = CLIP;
            CLIP:    state_nxt = drop ? DONE : FILL;
            FILL:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_r            <= '0;
            y_r            <= '0;
            w_r            <= '0;
            h_r            <= '0;
            w_eff          <= '0;
            h_eff          <= '0;
            col            <= '0;
            row            <= '0;
            bus.pxl_addr_o <= '0;
            bus.pxl_data_o <= '0;
            bus.pxl_en_o   <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
        end else begin
            bus.busy_o <= (state_nxt != IDLE);
            bus.done_o <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid_i) begin
                    x_r            <= bus.cmd_x_i;
                    y_r            <= bus.cmd_y_i;
                    w_r            <= bus.cmd_w_i;
                    h_r            <= bus.cmd_h_i;
                    bus.pxl_data_o <= bus.cmd_color_i;
                end
                CLIP: begin
                    w_eff <= w_clip;
                    h_eff <= h_clip;
                    col   <= '0;
                    row   <= '0;
                    if (drop) begin
                        bus.done_o <= 1'b1;
                    end else begin
                        bus.pxl_addr_o <= start_addr;
                        bus.pxl_en_o   <= 1'b1;
                    end
                end
                FILL: begin
                    if (last) begin
                        bus.pxl_en_o <= 1'b0;
                        bus.done_o   <= 1'b1;
                    end else if (col_end) begin
                        col            <= '0;
                        row            <= row + YW'(1);
                        bus.pxl_addr_o <= bus.pxl_addr_o + row_step;
                    end else begin
                        col            <= col + XW'(1);
                        bus.pxl_addr_o <= bus.pxl_addr_o + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill on an 8x4 framebuffer: inputs driven and
// outputs sampled on the falling edge, one cycle per negedge.
module tb_fb_rect_fill;
    localparam int FB_X = 8;
    localparam int FB_Y = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    fb_rect_fill_if #(.FB_X(FB_X), .FB_Y(FB_Y)) bus ();
    fb_rect_fill #(.FB_X(FB_X), .FB_Y(FB_Y)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Presents a command for the current cycle; call right after a negedge.
    task automatic drive(input logic [3:0] x, input logic [2:0] y, input logic [3:0] w,
                         input logic [2:0] h, input logic [23:0] c);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_x_i     = x;
        bus.cmd_y_i     = y;
        bus.cmd_w_i     = w;
        bus.cmd_h_i     = h;
        bus.cmd_color_i = c;
    endtask

    task automatic test_reset();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_x_i = '0; bus.cmd_y_i = '0; bus.cmd_w_i = '0; bus.cmd_h_i = '0;
        bus.cmd_color_i = '0;
        rst_n = 1'b0;
        #2;
        vecs++;
        if ({bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o} !== 4'b0001 ||
            bus.pxl_addr_o !== 5'd0 || bus.pxl_data_o !== 24'd0) begin
            errs++;
            $display("FAIL reset_outputs got en/busy/done/ready=%b addr=%0d data=%h want 0001 0 000000",
                     {bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o}, bus.pxl_addr_o, bus.pxl_data_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if ({bus.busy_o, bus.cmd_ready_o} !== 2'b01) begin
            errs++;
            $display("FAIL reset_release got busy/ready=%b want 01", {bus.busy_o, bus.cmd_ready_o});
        end
    endtask

    task automatic test_plain();
        logic [4:0] exp [6];
        exp = '{5'd10, 5'd11, 5'd12, 5'd18, 5'd19, 5'd20};
        drive(4'd2, 3'd1, 4'd3, 3'd2, 24'hFF0000);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        vecs++;
        if ({bus.pxl_en_o, bus.busy_o, bus.cmd_ready_o} !== 3'b010) begin
            errs++;
            $display("FAIL plain_clip got en/busy/ready=%b want 010",
                     {bus.pxl_en_o, bus.busy_o, bus.cmd_ready_o});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.pxl_en_o !== 1'b1 || bus.pxl_addr_o !== exp[i] ||
                bus.pxl_data_o !== 24'hFF0000 || bus.done_o !== 1'b0) begin
                errs++;
                $display("FAIL plain_wr[%0d] got en=%b addr=%0d data=%h done=%b want en=1 addr=%0d data=ff0000 done=0",
                         i, bus.pxl_en_o, bus.pxl_addr_o, bus.pxl_data_o, bus.done_o, exp[i]);
            end
        end
        @(negedge clk);
        vecs++;
        if ({bus.pxl_en_o, bus.done_o, bus.cmd_ready_o} !== 3'b010) begin
            errs++;
            $display("FAIL plain_done got en/done/ready=%b want 010",
                     {bus.pxl_en_o, bus.done_o, bus.cmd_ready_o});
        end
        @(negedge clk);
        vecs++;
        if ({bus.cmd_ready_o, bus.done_o, bus.busy_o} !== 3'b100) begin
            errs++;
            $display("FAIL plain_idle got ready/done/busy=%b want 100",
                     {bus.cmd_ready_o, bus.done_o, bus.busy_o});
        end
    endtask

    task automatic test_clip();
        logic [4:0] exp [2];
        exp = '{5'd30, 5'd31};
        drive(4'd6, 3'd3, 4'd5, 3'd4, 24'h00FF00);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.pxl_en_o !== 1'b1 || bus.pxl_addr_o !== exp[i] || bus.pxl_data_o !== 24'h00FF00) begin
                errs++;
                $display("FAIL clip_wr[%0d] got en=%b addr=%0d data=%h want en=1 addr=%0d data=00ff00",
                         i, bus.pxl_en_o, bus.pxl_addr_o, bus.pxl_data_o, exp[i]);
            end
        end
        @(negedge clk);
        vecs++;
        if ({bus.pxl_en_o, bus.done_o} !== 2'b01) begin
            errs++;
            $display("FAIL clip_done got en/done=%b want 01", {bus.pxl_en_o, bus.done_o});
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        logic [3:0] dx [2];
        logic [3:0] dw [2];
        logic [2:0] dh [2];
        // Per cycle T+1..T+4: {en, busy, done, ready}
        logic [3:0] exp [4];
        dx  = '{4'd8, 4'd0};
        dw  = '{4'd1, 4'd0};
        dh  = '{3'd1, 3'd3};
        exp = '{4'b0100, 4'b0110, 4'b0001, 4'b0001};
        for (int c = 0; c < 2; c++) begin
            drive(dx[c], 3'd0, dw[c], dh[c], 24'h0000FF);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus.cmd_valid_i = 1'b0;
                vecs++;
                if ({bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o} !== exp[k]) begin
                    errs++;
                    $display("FAIL drop%0d_T+%0d got en/busy/done/ready=%b want %b",
                             c, k + 1, {bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o}, exp[k]);
                end
            end
        end
    endtask

    task automatic test_full();
        drive(4'd0, 3'd0, 4'd8, 3'd4, 24'h123456);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.pxl_en_o !== 1'b1 || bus.pxl_addr_o !== 5'(i) || bus.pxl_data_o !== 24'h123456) begin
                errs++;
                $display("FAIL full_wr[%0d] got en=%b addr=%0d data=%h want en=1 addr=%0d data=123456",
                         i, bus.pxl_en_o, bus.pxl_addr_o, bus.pxl_data_o, i);
            end
        end
        @(negedge clk);
        vecs++;
        if ({bus.pxl_en_o, bus.done_o} !== 2'b01) begin
            errs++;
            $display("FAIL full_done got en/done=%b want 01", {bus.pxl_en_o, bus.done_o});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Per cycle T+1..T+9: {en, busy, done, ready}; second command taken at T+5.
        logic [3:0] exp [9];
        logic [4:0] ea  [9];
        exp = '{4'b0100, 4'b1100, 4'b1100, 4'b0110, 4'b0001,
                4'b0100, 4'b1100, 4'b0110, 4'b0001};
        ea  = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd20, 5'd0, 5'd0};
        drive(4'd0, 3'd0, 4'd2, 3'd1, 24'hAAAAAA);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) drive(4'd4, 3'd2, 4'd1, 3'd1, 24'h555555);
            if (k == 5) bus.cmd_valid_i = 1'b0;
            vecs++;
            if ({bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o} !== exp[k] ||
                (exp[k][3] && bus.pxl_addr_o !== ea[k])) begin
                errs++;
                $display("FAIL b2b_T+%0d got en/busy/done/ready=%b addr=%0d want %b addr=%0d",
                         k + 1, {bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o},
                         bus.pxl_addr_o, exp[k], ea[k]);
            end
            if (k == 6) begin
                vecs++;
                if (bus.pxl_data_o !== 24'h555555) begin
                    errs++;
                    $display("FAIL b2b_data got %h want 555555", bus.pxl_data_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        drive(4'd0, 3'd0, 4'd8, 3'd4, 24'h0F0F0F);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (bus.pxl_en_o !== 1'b1 || bus.pxl_addr_o !== 5'd2) begin
            errs++;
            $display("FAIL rst_mid_pre got en=%b addr=%0d want en=1 addr=2", bus.pxl_en_o, bus.pxl_addr_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o} !== 4'b0001 ||
            bus.pxl_addr_o !== 5'd0 || bus.pxl_data_o !== 24'd0) begin
            errs++;
            $display("FAIL rst_mid_async got en/busy/done/ready=%b addr=%0d data=%h want 0001 0 000000",
                     {bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o}, bus.pxl_addr_o, bus.pxl_data_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vecs++;
            if ({bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o} !== 4'b0001) begin
                errs++;
                $display("FAIL rst_mid_after[%0d] got en/busy/done/ready=%b want 0001",
                         k, {bus.pxl_en_o, bus.busy_o, bus.done_o, bus.cmd_ready_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_clip();
        test_drop();
        test_full();
        test_back_to_back();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
